// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types and constants for the Q7.8 sign-magnitude ALU sequencer
package fxp_pkg;
  typedef logic [15:0] fxp_t;
  localparam logic [2:0] FXP_OP_ADD = 3'b000;
  localparam logic [2:0] FXP_OP_MUL = 3'b010;
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_EXEC, S_WRITE, S_DONE} seq_state_t;
endpackage

// File: rtl/fxp_alu_sequencer.sv
// fxp_alu_sequencer: walks operand RAMs through the external ALU into a result RAM.
// FXP_SEQ_SATURATE_EN: clamp overflowing add results to full-scale magnitude.
module fxp_alu_sequencer
  import fxp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              ovf_sticky,
  output logic [ADDR_W:0]   zero_count
);
  seq_state_t        state_q, state_d;
  logic [2:0]        op_q, op_d, alu_ctrl_q, alu_ctrl_d;
  logic [ADDR_W:0]   length_q, length_d, zcnt_q, zcnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic              ovf_q, ovf_d, elem_ovf, unused_ok;
  // C is not driven by the ALU on mul, so only add results can overflow here
  assign elem_ovf = op_q == FXP_OP_ADD && (flags_q[FLAG_V] || flags_q[FLAG_C]);
  assign unused_ok = flags_q[FLAG_N];
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    length_d   = length_q;
    idx_d      = idx_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    res_d      = res_q;
    flags_d    = flags_q;
    ovf_d      = ovf_q;
    zcnt_d     = zcnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d     = op;
        length_d = length;
        idx_d    = '0;
        ovf_d    = 1'b0;
        zcnt_d   = '0;
        state_d  = length == '0 ? S_DONE : S_READ;
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        alu_a_d    = rd_data_a;
        alu_b_d    = rd_data_b;
        alu_ctrl_d = op_q;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_result;
        flags_d = alu_flags;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        zcnt_d  = zcnt_q + (ADDR_W+1)'(flags_q[FLAG_Z]);
        ovf_d   = ovf_q | elem_ovf;
        idx_d   = {1'b0, idx_q} == length_q - 1'b1 ? idx_q : idx_q + 1'b1;
        state_d = {1'b0, idx_q} == length_q - 1'b1 ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      length_q   <= '0;
      idx_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      ovf_q      <= 1'b0;
      zcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      length_q   <= length_d;
      idx_q      <= idx_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      ovf_q      <= ovf_d;
      zcnt_q     <= zcnt_d;
    end
  end
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign wr_en      = state_q == S_WRITE;
  assign rd_addr    = idx_q;
  assign wr_addr    = idx_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign ovf_sticky = ovf_q;
  assign zero_count = zcnt_q;
`ifdef FXP_SEQ_SATURATE_EN
  assign wr_data = elem_ovf ? {alu_a_q[DATA_W-1], {(DATA_W-1){1'b1}}} : res_q;
`else
  assign wr_data = res_q;
`endif
endmodule

// File: tb/tb_fxp_alu_sequencer.sv
// tb_fxp_alu_sequencer: directed checks of the sequencer with RAM and ALU models
module tb_fxp_alu_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [8:0] length = '0, zero_count;
  logic busy, done, wr_en, ovf_sticky;
  logic [7:0] rd_addr, wr_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data, alu_a, alu_b, alu_result;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_flags;
  logic [15:0] mem_a [256], mem_b [256], res_mem [256];
  int wr_cnt = 0, total = 0, bad = 0, n, base;
  logic [14:0] ma, mb, mag;
  logic [15:0] s;
  logic [29:0] p;
  logic sg, c_f, v_f;

  fxp_alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .length(length), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .ovf_sticky(ovf_sticky), .zero_count(zero_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data_a <= mem_a[rd_addr];
    rd_data_b <= mem_b[rd_addr];
    if (wr_en) begin
      res_mem[wr_addr] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // sign-magnitude Q7.8 ALU model; mul leaves C at 0
  always_comb begin
    ma = alu_a[14:0];
    mb = alu_b[14:0];
    s = '0;
    p = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    if (alu_ctrl == 3'b010) begin
      p = 30'(ma) * 30'(mb);
      mag = p[22:8];
      v_f = |p[29:23];
      sg = alu_a[15] ^ alu_b[15];
    end else if (alu_a[15] == alu_b[15]) begin
      s = {1'b0, ma} + {1'b0, mb};
      mag = s[14:0];
      c_f = s[15];
      v_f = s[15];
      sg = alu_a[15];
    end else begin
      mag = ma >= mb ? ma - mb : mb - ma;
      sg = ma >= mb ? alu_a[15] : alu_b[15];
    end
    alu_result = {sg && mag != '0, mag};
    alu_flags = {alu_result[15], mag == '0, v_f, c_f};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [8:0] l, input int pulse_at, output int cyc);
    @(negedge clk);
    op = o;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1200) begin
      start = cyc == pulse_at;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 1200) check("done_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      res_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_ovf", 32'(ovf_sticky), 0);
    check("rst_zc", 32'(zero_count), 0);
    rst = 1'b0;

    // 1: add, length 1
    mem_a[0] = 16'h0180; mem_b[0] = 16'h0100;
    base = wr_cnt;
    run(3'b000, 9'd1, 0, n);
    check("t1_latency", 32'(n), 32'd5);
    check("t1_data", 32'(res_mem[0]), 32'h0280);
    check("t1_writes", 32'(wr_cnt - base), 32'd1);
    check("t1_ovf", 32'(ovf_sticky), 0);
    check("t1_busy_in_done", 32'(busy), 1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);

    // 2: mul, length 2, with an ignored start mid-run
    mem_a[0] = 16'h0080; mem_b[0] = 16'h0100;
    mem_a[1] = 16'h0100; mem_b[1] = 16'h0100;
    run(3'b010, 9'd2, 4, n);
    check("t2_latency", 32'(n), 32'd9);
    check("t2_data0", 32'(res_mem[0]), 32'h0080);
    check("t2_data1", 32'(res_mem[1]), 32'h0100);
    repeat (3) begin
      @(negedge clk);
      check("t2_no_requeue", 32'(busy), 0);
    end

    // 3: add carry out
    mem_a[0] = 16'h7F00; mem_b[0] = 16'h0200;
    run(3'b000, 9'd1, 0, n);
    check("t3_ovf", 32'(ovf_sticky), 1);
`ifdef FXP_SEQ_SATURATE_EN
    check("t3_data", 32'(res_mem[0]), 32'h7FFF);
`else
    check("t3_data", 32'(res_mem[0]), 32'h0100);
`endif
    @(negedge clk);
    check("t3_ovf_hold", 32'(ovf_sticky), 1);

    // 3b: mul overflow does not set the sticky flag, which start cleared
    run(3'b010, 9'd1, 0, n);
    check("t3b_ovf", 32'(ovf_sticky), 0);
    check("t3b_data", 32'(res_mem[0]), 32'h7E00);

    // 4: +1 + -1 is zero
    mem_a[0] = 16'h0100; mem_b[0] = 16'h8100;
    run(3'b000, 9'd1, 0, n);
    check("t4_data", 32'(res_mem[0]), 32'h0000);
    check("t4_zc", 32'(zero_count), 1);

    // 5: length 0
    base = wr_cnt;
    run(3'b000, 9'd0, 0, n);
    check("t5_latency", 32'(n), 32'd1);
    check("t5_writes", 32'(wr_cnt - base), 0);
    check("t5_zc", 32'(zero_count), 0);

    // full RAM: A[i]=i, B[i]=1/256
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'h0001;
    end
    base = wr_cnt;
    run(3'b000, 9'd256, 0, n);
    check("full_latency", 32'(n), 32'd1025);
    check("full_writes", 32'(wr_cnt - base), 32'd256);
    check("full_first", 32'(res_mem[0]), 32'h0001);
    check("full_last", 32'(res_mem[255]), 32'h0100);
    check("full_rd_addr", 32'(rd_addr), 32'd255);
    @(negedge clk);
    check("full_rd_hold", 32'(rd_addr), 32'd255);

    // 6: reset after the second write of a length-4 run
    base = wr_cnt;
    @(negedge clk);
    op = 3'b000; length = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wr_cnt - base < 2 && n < 50) begin
      start = n == 3;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("t6_two_writes", 32'(wr_cnt - base), 32'd2);
    check("t6_busy_mid", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_idx_rst", 32'(rd_addr), 0);
    check("t6_wr_en_rst", 32'(wr_en), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_no_writes", 32'(wr_cnt - base), 32'd2);
    check("t6_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
